// File: rtl/wrap_field_counter_pkg.sv
// Shared definitions for the wrap_field_counter slice.
//   btn_state_e   : button auto-repeat FSM states
//   DefRptDelay   : default rpt_tick strobes of hold before auto-repeat starts
//   DefRptRate    : default rpt_tick strobes between auto-repeat steps
//   cnt_width()   : bits needed for a counter running 0 .. max_count-1
package wrap_field_counter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPress,
        StRepeat
    } btn_state_e;

    localparam int unsigned DefRptDelay = 8;
    localparam int unsigned DefRptRate  = 2;

    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count > 1) ? int'($clog2(max_count)) : 1;
    endfunction

endpackage

// File: rtl/wrap_field_counter_if.sv
// Control/status bundle of wrap_field_counter.
//   master : the controller (drives strobes/buttons/load, observes the field)
//   slave  : the counter itself
// Signals:
//   tick, count_dn        carry/borrow-in strobe and its direction (1 = down)
//   manual_set, up, down  manual adjust mode and button levels
//   rpt_tick              slow auto-repeat timing strobe
//   load, load_val        load strobe and value
//   value                 current field value
//   carry_out, borrow_out wrap pulses (tick steps only)
//   load_err              rejected-load pulse
//   at_limit              value sits at the terminal value for count_dn
interface wrap_field_counter_if #(
    parameter int unsigned WIDTH = 6
);
    logic             tick;
    logic             count_dn;
    logic             manual_set;
    logic             up;
    logic             down;
    logic             rpt_tick;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] value;
    logic             carry_out;
    logic             borrow_out;
    logic             load_err;
    logic             at_limit;

    modport master (
        output tick, count_dn, manual_set, up, down, rpt_tick, load, load_val,
        input  value, carry_out, borrow_out, load_err, at_limit
    );

    modport slave (
        input  tick, count_dn, manual_set, up, down, rpt_tick, load, load_val,
        output value, carry_out, borrow_out, load_err, at_limit
    );
endinterface

// File: rtl/btn_repeat_fsm.sv
// Button front end for manual field adjustment: turns up/down levels into one-cycle
// step_up_o/step_dn_o pulses.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   up_i, down_i          button levels (already synchronised)
//   manual_set_i, load_i  steps only allowed with manual_set high and no load
//   rpt_tick_i            auto-repeat timing strobe
//   step_up_o, step_dn_o  one-cycle step requests
// Build option WFC_AUTOREPEAT_EN: when defined, a held button auto-repeats after
// RPT_DELAY rpt_ticks, then every RPT_RATE rpt_ticks. Otherwise only press edges step.
module btn_repeat_fsm
    import wrap_field_counter_pkg::*;
#(
    parameter int unsigned RPT_DELAY = DefRptDelay,
    parameter int unsigned RPT_RATE  = DefRptRate
) (
    input  logic clk,
    input  logic rst_n,
    input  logic up_i,
    input  logic down_i,
    input  logic manual_set_i,
    input  logic load_i,
    input  logic rpt_tick_i,
    output logic step_up_o,
    output logic step_dn_o
);
    logic act_up, act_dn, rise_up, rise_dn, enable;
    logic prev_up_q, prev_up_d, prev_dn_q, prev_dn_d;
    // Cleared by reset so a button held across reset release never looks like a press.
    logic armed_q, armed_d;

    assign act_up  = up_i & ~down_i;
    assign act_dn  = down_i & ~up_i;
    assign rise_up = armed_q & act_up & ~prev_up_q;
    assign rise_dn = armed_q & act_dn & ~prev_dn_q;
    assign enable  = manual_set_i & ~load_i;

    always_comb begin
        prev_up_d = act_up;
        prev_dn_d = act_dn;
        armed_d   = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_up_q <= 1'b0;
            prev_dn_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            prev_up_q <= prev_up_d;
            prev_dn_q <= prev_dn_d;
            armed_q   <= armed_d;
        end
    end

`ifdef WFC_AUTOREPEAT_EN
    localparam int unsigned CntMax = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int unsigned CntW   = cnt_width(CntMax);
    localparam logic [CntW-1:0] DelayLast = CntW'(RPT_DELAY - 1);
    localparam logic [CntW-1:0] RateLast  = CntW'(RPT_RATE - 1);

    btn_state_e      state_q, state_d;
    logic            dir_dn_q, dir_dn_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            held;

    always_comb begin
        state_d   = state_q;
        dir_dn_d  = dir_dn_q;
        cnt_d     = cnt_q;
        step_up_o = 1'b0;
        step_dn_o = 1'b0;
        // The button that started the press must still be the only one down.
        held      = dir_dn_q ? act_dn : act_up;
        unique case (state_q)
            StIdle: begin
                if (enable && (rise_up || rise_dn)) begin
                    state_d   = StPress;
                    dir_dn_d  = rise_dn;
                    cnt_d     = '0;
                    step_up_o = rise_up;
                    step_dn_o = rise_dn;
                end
            end
            StPress, StRepeat: begin
                if (!enable || !held) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (rpt_tick_i) begin
                    if (cnt_q == ((state_q == StPress) ? DelayLast : RateLast)) begin
                        state_d   = StRepeat;
                        cnt_d     = '0;
                        step_up_o = ~dir_dn_q;
                        step_dn_o = dir_dn_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            dir_dn_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_dn_q <= dir_dn_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    logic unused_rpt_tick;
    assign unused_rpt_tick = rpt_tick_i;

    always_comb begin
        step_up_o = enable & rise_up;
        step_dn_o = enable & rise_dn;
    end
`endif

endmodule

// File: rtl/wrap_field_counter.sv
// Wrapping field counter (e.g. hours of a clock) adjustable by carry/borrow ticks,
// manual up/down buttons and a range-checked load. Priority: load > manual_set > tick.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         wrap_field_counter_if.slave (strobes, buttons, load, value, pulses)
// Build option WFC_AUTOREPEAT_EN enables button auto-repeat in btn_repeat_fsm.
module wrap_field_counter
    import wrap_field_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned MIN_VAL   = 0,
    parameter int unsigned MAX_VAL   = 23,
    parameter int unsigned RPT_DELAY = DefRptDelay,
    parameter int unsigned RPT_RATE  = DefRptRate
) (
    input logic                 clk,
    input logic                 rst_n,
    wrap_field_counter_if.slave bus
);
    if (!(MIN_VAL < MAX_VAL) || ((longint'(MAX_VAL) >> WIDTH) != 0)) begin : g_bad_range
        $error("wrap_field_counter: need MIN_VAL < MAX_VAL < 2**WIDTH");
    end
    if (RPT_RATE < 1 || RPT_DELAY < 1) begin : g_bad_rpt
        $error("wrap_field_counter: RPT_RATE and RPT_DELAY must be >= 1");
    end

    localparam logic [WIDTH-1:0] MinV = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);
    localparam bit MaxIsFull = (longint'(MAX_VAL) == ((longint'(1) << WIDTH) - 1));

    logic             step_up, step_dn;
    logic             below_min, above_max;
    logic [WIDTH-1:0] inc_wrap, dec_wrap;
    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d, borrow_q, borrow_d, load_err_q, load_err_d;

    btn_repeat_fsm #(
        .RPT_DELAY (RPT_DELAY),
        .RPT_RATE  (RPT_RATE)
    ) u_btn (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_i         (bus.up),
        .down_i       (bus.down),
        .manual_set_i (bus.manual_set),
        .load_i       (bus.load),
        .rpt_tick_i   (bus.rpt_tick),
        .step_up_o    (step_up),
        .step_dn_o    (step_dn)
    );

    // Bounds that cannot be violated at this width are tied off to keep compares meaningful.
    if (MIN_VAL == 0) begin : g_no_min
        assign below_min = 1'b0;
    end else begin : g_min
        assign below_min = bus.load_val < MinV;
    end
    if (MaxIsFull) begin : g_no_max
        assign above_max = 1'b0;
    end else begin : g_max
        assign above_max = bus.load_val > MaxV;
    end

    // Compare before stepping so the result never relies on WIDTH-bit overflow.
    assign inc_wrap = (value_q == MaxV) ? MinV : value_q + 1'b1;
    assign dec_wrap = (value_q == MinV) ? MaxV : value_q - 1'b1;

    always_comb begin
        value_d    = value_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (below_min || above_max) begin
                load_err_d = 1'b1;
            end else begin
                value_d = bus.load_val;
            end
        end else if (bus.manual_set) begin
            // Ticks are dropped while adjusting; manual wraps raise no carry/borrow.
            if (step_up) begin
                value_d = inc_wrap;
            end else if (step_dn) begin
                value_d = dec_wrap;
            end
        end else if (bus.tick) begin
            if (bus.count_dn) begin
                value_d  = dec_wrap;
                borrow_d = (value_q == MinV);
            end else begin
                value_d = inc_wrap;
                carry_d = (value_q == MaxV);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q    <= MinV;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.value      = value_q;
    assign bus.carry_out  = carry_q;
    assign bus.borrow_out = borrow_q;
    assign bus.load_err   = load_err_q;
    assign bus.at_limit   = ((value_q == MaxV) && !bus.count_dn) ||
                            ((value_q == MinV) && bus.count_dn);

endmodule

// File: tb/tb_wrap_field_counter.sv
// Self-checking bench for wrap_field_counter (WIDTH=6, MIN=0, MAX=23, RPT_DELAY=4,
// RPT_RATE=2): directed scenarios with literal expectations, then randomized stimulus,
// all checked every cycle against a behavioural model. Honours WFC_AUTOREPEAT_EN.
module tb_wrap_field_counter;
    localparam int MinV = 0;
    localparam int MaxV = 23;
    localparam int Dly  = 4;
    localparam int Rate = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    wrap_field_counter_if #(.WIDTH(6)) bus ();

    wrap_field_counter #(
        .WIDTH     (6),
        .MIN_VAL   (MinV),
        .MAX_VAL   (MaxV),
        .RPT_DELAY (Dly),
        .RPT_RATE  (Rate)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_value  = MinV;
    bit m_carry  = 1'b0;
    bit m_borrow = 1'b0;
    bit m_err    = 1'b0;
    bit m_armed  = 1'b0;
    bit m_pau    = 1'b0;
    bit m_pad    = 1'b0;
`ifdef WFC_AUTOREPEAT_EN
    bit m_pressed = 1'b0;
    bit m_hdir    = 1'b0;  // 1 = down
    int m_n       = 0;     // rpt_ticks seen since the press
`endif

    task automatic model_reset();
        m_value = MinV; m_carry = 0; m_borrow = 0; m_err = 0;
        m_armed = 0; m_pau = 0; m_pad = 0;
`ifdef WFC_AUTOREPEAT_EN
        m_pressed = 0; m_n = 0;
`endif
    endtask

    task automatic model_step();
        bit au, ad, ru, rd, en;
        int step, lv;
        au   = bus.up && !bus.down;
        ad   = bus.down && !bus.up;
        ru   = m_armed && au && !m_pau;
        rd   = m_armed && ad && !m_pad;
        en   = bus.manual_set && !bus.load;
        step = 0;
`ifdef WFC_AUTOREPEAT_EN
        if (m_pressed) begin
            if (!en || !(m_hdir ? ad : au)) begin
                m_pressed = 0;
            end else if (bus.rpt_tick) begin
                m_n++;
                if (m_n == Dly || (m_n > Dly && (m_n - Dly) % Rate == 0))
                    step = m_hdir ? -1 : 1;
            end
        end else if (en && (ru || rd)) begin
            m_pressed = 1; m_hdir = rd; m_n = 0;
            step = rd ? -1 : 1;
        end
`else
        if (en && ru) step = 1;
        else if (en && rd) step = -1;
`endif
        m_pau = au; m_pad = ad; m_armed = 1;
        m_carry = 0; m_borrow = 0; m_err = 0;
        lv = int'(bus.load_val);
        if (bus.load) begin
            if (lv >= MinV && lv <= MaxV) m_value = lv;
            else m_err = 1;
        end else if (bus.manual_set) begin
            if (step != 0) begin
                m_value = m_value + step;
                if (m_value > MaxV) m_value = MinV;
                if (m_value < MinV) m_value = MaxV;
            end
        end else if (bus.tick) begin
            if (bus.count_dn) begin
                if (m_value == MinV) begin m_value = MaxV; m_borrow = 1; end
                else m_value--;
            end else begin
                if (m_value == MaxV) begin m_value = MinV; m_carry = 1; end
                else m_value++;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: dut=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("value", int'(bus.value), m_value);
        chk("carry_out", int'(bus.carry_out), int'(m_carry));
        chk("borrow_out", int'(bus.borrow_out), int'(m_borrow));
        chk("load_err", int'(bus.load_err), int'(m_err));
        chk("at_limit", int'(bus.at_limit),
            int'((m_value == MaxV && !bus.count_dn) || (m_value == MinV && bus.count_dn)));
    end

    // ---------------- stimulus ----------------
    task automatic clk1();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input int v);
        bus.load = 1; bus.load_val = 6'(v);
        clk1();
        bus.load = 0;
    endtask

    // Value and model both pinned to a hand-computed literal.
    task automatic lit(input string name, input int exp);
        chk(name, int'(bus.value), exp);
        chk({name, "_model"}, m_value, exp);
    endtask

    int rep_exp[10];

    initial begin
        bus.tick = 0; bus.count_dn = 0; bus.manual_set = 0; bus.up = 0; bus.down = 0;
        bus.rpt_tick = 0; bus.load = 0; bus.load_val = '0;
        #1 rst_n = 0;
        clk1(); clk1();
        lit("reset_value", 0);
        chk("reset_carry", int'(bus.carry_out), 0);
        chk("reset_err", int'(bus.load_err), 0);
        rst_n = 1;
        clk1();

        // Carry wrap at MAX
        do_load(23);
        lit("load23", 23);
        chk("at_limit_up", int'(bus.at_limit), 1);
        bus.tick = 1; bus.count_dn = 0;
        clk1();
        bus.tick = 0;
        lit("carry_wrap", 0);
        chk("carry_pulse", int'(bus.carry_out), 1);
        clk1();
        chk("carry_end", int'(bus.carry_out), 0);

        // Borrow wrap at MIN, then manual wrap without borrow
        bus.tick = 1; bus.count_dn = 1;
        clk1();
        bus.tick = 0;
        lit("borrow_wrap", 23);
        chk("borrow_pulse", int'(bus.borrow_out), 1);
        clk1();
        chk("borrow_end", int'(bus.borrow_out), 0);
        do_load(0);
        bus.manual_set = 1; bus.down = 1;
        clk1();
        lit("manual_wrap", 23);
        chk("manual_no_borrow", int'(bus.borrow_out), 0);
        bus.down = 0;
        clk1();

        // Held up button with rpt_ticks from 5
`ifdef WFC_AUTOREPEAT_EN
        rep_exp = '{6, 6, 6, 7, 7, 8, 8, 9, 9, 10};
`else
        rep_exp = '{6, 6, 6, 6, 6, 6, 6, 6, 6, 6};
`endif
        do_load(5);
        bus.count_dn = 0; bus.up = 1;
        clk1();
        lit("press_step", 6);
        for (int k = 0; k < 10; k++) begin
            bus.rpt_tick = 1;
            clk1();
            bus.rpt_tick = 0;
            lit($sformatf("hold_tick%0d", k + 1), rep_exp[k]);
            clk1();
        end

        // Reset mid-hold, button held across release
        rst_n = 0;
        #1 lit("async_reset", 0);
        clk1(); clk1();
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            bus.rpt_tick = 1; clk1(); bus.rpt_tick = 0; clk1();
        end
        lit("held_after_reset", 0);
        bus.up = 0; clk1();
        bus.up = 1; clk1();
        lit("repress", 1);
        bus.up = 0; clk1();

        // Both buttons
        bus.up = 1; bus.down = 1;
        for (int k = 0; k < 6; k++) begin
            bus.rpt_tick = 1; clk1(); bus.rpt_tick = 0; clk1();
        end
        lit("both_held", 1);
        bus.up = 0; bus.down = 0; clk1();

        // Rejected load, then load beating tick
        bus.manual_set = 0;
        do_load(30);
        lit("bad_load", 1);
        chk("load_err_pulse", int'(bus.load_err), 1);
        clk1();
        chk("load_err_end", int'(bus.load_err), 0);
        do_load(23);
        bus.tick = 1; bus.count_dn = 0;
        do_load(12);
        bus.tick = 0;
        lit("load_over_tick", 12);
        chk("load_over_tick_carry", int'(bus.carry_out), 0);
        clk1();

        // Randomized phase
        bus.manual_set = 1;
        for (int c = 0; c < 3000; c++) begin
            bus.load     = ($urandom_range(0, 39) == 0);
            bus.load_val = 6'($urandom_range(0, 40));
            if ($urandom_range(0, 39) == 0) bus.manual_set = ~bus.manual_set;
            if ($urandom_range(0, 19) == 0) bus.up = ~bus.up;
            if ($urandom_range(0, 19) == 0) bus.down = ~bus.down;
            bus.rpt_tick = ($urandom_range(0, 2) == 0);
            bus.tick     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) bus.count_dn = ~bus.count_dn;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 0; clk1(); rst_n = 1;
            end
            clk1();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
